bus_arb: RTL and testbench
==========================

BUS_ARB -- requirements
Module: bus_arb

Interface
REQ-001 Parameter BLK_LEN, default 58, SHALL set the cache-line block address width.
REQ-002 Parameter LINE, default 512, SHALL set the line data width in bits.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset; asynchronous assertion, active-low.
REQ-005 b_addr_i  in  BLK_LEN  imem fill block address.
REQ-006 b_rd_i  in  1  imem fill request; held until b_dv_i.
REQ-007 b_rdata_i  out  LINE  imem fill data.
REQ-008 b_dv_i  out  1  imem fill data valid, one-cycle pulse.
REQ-009 b_addr_d, b_rd_d, b_rdata_d, b_dv_d  SHALL form the dmem port, with the same widths, directions and meaning as REQ-005..REQ-008.
REQ-010 m_addr  out  BLK_LEN  external memory block address.
REQ-011 m_rd  out  1  external read request.
REQ-012 m_rdata  in  LINE  external read data.
REQ-013 m_ack  in  1  external data valid, one-cycle pulse.
REQ-014 x_inv_addr  in  BLK_LEN  external invalidate address.
REQ-015 x_inv  in  1  external invalidate strobe, one-cycle pulse.
REQ-016 b_inv_addr  out  BLK_LEN  invalidate address to both caches.
REQ-017 inv  out  1  invalidate strobe to both caches, one-cycle pulse.

Function
REQ-018 The FSM SHALL have states IDLE, GNT_I, GNT_D and DONE.
REQ-019 IDLE SHALL move to GNT_D when only b_rd_d is set, and to GNT_I when only b_rd_i is set.
REQ-020 IDLE with both requests set SHALL grant the port not granted last (round robin); after reset dmem SHALL win the first tie.
REQ-021 On entering a GNT state, m_addr SHALL latch the winner's address and stay stable until DONE.
REQ-022 m_rd SHALL be 1 exactly in GNT_I/GNT_D.
REQ-023 m_ack in GNT_x SHALL pulse b_dv_x in the same cycle (combinational), and the FSM SHALL then move to DONE.
REQ-024 b_rdata_i and b_rdata_d SHALL both equal m_rdata combinationally at all times.
REQ-025 b_dv of the non-granted port SHALL stay 0; m_ack outside GNT states SHALL be ignored.
REQ-026 DONE SHALL last exactly 1 cycle, then return to IDLE; no request is sampled in DONE, so a requester still holding rd is not re-granted.
REQ-027 Minimum latency: request seen in IDLE at cycle N -> m_rd at N+1; m_ack at N+k -> b_dv at N+k; next grant no earlier than N+k+2.
REQ-028 x_inv SHALL normally be forwarded to inv/b_inv_addr registered, 1 cycle later.
REQ-029 If x_inv arrives in a GNT state with x_inv_addr == m_addr, it SHALL be held in a one-entry pending buffer and issued in the DONE cycle instead.
REQ-030 A second x_inv while the buffer is full SHALL be forwarded normally if its address differs; if the address matches, it SHALL be merged into the buffer (single issue).
REQ-031 inv SHALL never assert twice for one x_inv pulse; merged pulses SHALL issue once.

Reset
REQ-032 With rst_n low: state=IDLE, last-grant=imem, m_rd=0, m_addr=0, b_dv_i=b_dv_d=0, inv=0, b_inv_addr=0, pending buffer empty.
REQ-033 Reset during GNT SHALL drop m_rd immediately; no b_dv pulse occurs for the aborted fill.

Structure
REQ-034 State encodings and the BLK_LEN/LINE defaults SHALL live in the shared core config include (same place as the DMEM_* constants).
REQ-035 The block SHALL be a single module with no sub-modules.

Verification
REQ-036 Only b_rd_d with addr 0x100, m_ack 3 cycles later -> m_addr=0x100, m_rd for 3 cycles, one b_dv_d pulse, b_dv_i stays 0.
REQ-037 b_rd_i and b_rd_d set in the same cycle after reset -> dmem granted first, imem second; repeat the tie -> imem first.
REQ-038 Requester holds rd 1 cycle past b_dv -> no second m_rd; DONE observed for exactly 1 cycle.
REQ-039 x_inv to 0x100 during a dmem fill of 0x100 -> inv held, then inv=1 with b_inv_addr=0x100 in the DONE cycle; x_inv to 0x200 in the same window -> inv 1 cycle later.
REQ-040 rst_n pulsed low mid-GNT_I -> m_rd=0 asynchronously; a later m_ack produces no b_dv.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared configuration for the bus arbiter: FSM state encodings, port ids,
// and the default block-address / line widths used across the memory core.
package bus_arb_pkg;

    localparam int BLK_LEN_DEF = 58;
    localparam int LINE_DEF    = 512;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT_I = 2'd1;
    localparam logic [1:0] ST_GNT_D = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Identity of the port that most recently won the bus.
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    function automatic logic is_gnt(input logic [1:0] st);
        return (st == ST_GNT_I) || (st == ST_GNT_D);
    endfunction

endpackage

// File: rtl/bus_arb.sv
// Round-robin arbiter between the imem and dmem line-fill ports onto one
// external memory read port, plus invalidate forwarding that defers hits on the in-flight line.
module bus_arb
    import bus_arb_pkg::*;
#(
    parameter int BLK_LEN = BLK_LEN_DEF,
    parameter int LINE    = LINE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic [BLK_LEN-1:0] b_addr_i,
    input  logic               b_rd_i,
    output logic [LINE-1:0]    b_rdata_i,
    output logic               b_dv_i,

    input  logic [BLK_LEN-1:0] b_addr_d,
    input  logic               b_rd_d,
    output logic [LINE-1:0]    b_rdata_d,
    output logic               b_dv_d,

    output logic [BLK_LEN-1:0] m_addr,
    output logic               m_rd,
    input  logic [LINE-1:0]    m_rdata,
    input  logic               m_ack,

    input  logic [BLK_LEN-1:0] x_inv_addr,
    input  logic               x_inv,
    output logic [BLK_LEN-1:0] b_inv_addr,
    output logic               inv,

    output logic [1:0]         dbg_state
);

    // Handshake: a requester raises b_rd_x with b_addr_x stable and holds both
    // until it sees b_dv_x (one cycle, combinational from m_ack during its
    // grant). m_rd is high for the whole grant; m_ack is a one-cycle data
    // strobe and is ignored whenever no grant is active.

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       last_q;
    logic       grant_i;
    logic       grant_d;
    logic       in_gnt;
    logic       go_done;

    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (b_rd_i && b_rd_d) begin
                    if (last_q == PORT_I) grant_d = 1'b1;
                    else                  grant_i = 1'b1;
                end else if (b_rd_d) begin
                    grant_d = 1'b1;
                end else if (b_rd_i) begin
                    grant_i = 1'b1;
                end
                if (grant_d)      state_d = ST_GNT_D;
                else if (grant_i) state_d = ST_GNT_I;
            end
            ST_GNT_I, ST_GNT_D: begin
                if (m_ack) state_d = ST_DONE;
            end
            // One dead cycle so a requester still holding rd is not re-granted.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= PORT_I;
            m_addr  <= '0;
        end else begin
            state_q <= state_d;
            if (grant_d) begin
                m_addr <= b_addr_d;
                last_q <= PORT_D;
            end else if (grant_i) begin
                m_addr <= b_addr_i;
                last_q <= PORT_I;
            end
        end
    end

    assign in_gnt    = is_gnt(state_q);
    assign go_done   = in_gnt && m_ack;
    assign m_rd      = in_gnt;
    assign b_dv_i    = (state_q == ST_GNT_I) && m_ack;
    assign b_dv_d    = (state_q == ST_GNT_D) && m_ack;
    assign b_rdata_i = m_rdata;
    assign b_rdata_d = m_rdata;
    assign dbg_state = state_q;

    // An invalidate hitting the line being filled is parked so the cache sees
    // it after the fill lands; everything else goes out one cycle later.
    logic               pend_valid;
    logic [BLK_LEN-1:0] pend_addr;
    logic               buf_conflict;
    logic               hold;
    logic               fwd;
    logic               pend_v_eff;
    logic [BLK_LEN-1:0] pend_a_eff;
    logic               issue_pend;

    always_comb begin
        buf_conflict = pend_valid && (pend_addr != x_inv_addr);
        hold         = x_inv && in_gnt && (x_inv_addr == m_addr) && !buf_conflict;
        fwd          = x_inv && !hold;
        pend_v_eff   = pend_valid || hold;
        pend_a_eff   = pend_valid ? pend_addr : x_inv_addr;
        // The parked entry goes out in DONE; a same-cycle forward wins the
        // single output slot and the entry drains on the next free cycle.
        issue_pend   = pend_v_eff && (go_done || !in_gnt) && !fwd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv        <= 1'b0;
            b_inv_addr <= '0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
        end else begin
            inv <= fwd || issue_pend;
            if (fwd)             b_inv_addr <= x_inv_addr;
            else if (issue_pend) b_inv_addr <= pend_a_eff;
            pend_valid <= pend_v_eff && !issue_pend;
            if (hold && !pend_valid) pend_addr <= x_inv_addr;
        end
    end

endmodule

// File: tb/tb_bus_arb.sv
// Directed bench for bus_arb: reset state, single fills, round-robin ties,
// DONE spacing, invalidate deferral/merge, and reset abort of a fill.
module tb_bus_arb;
    import bus_arb_pkg::*;

    localparam int BL = 58;
    localparam int LN = 512;

    logic          clk;
    logic          rst_n;
    logic [BL-1:0] b_addr_i, b_addr_d, m_addr, x_inv_addr, b_inv_addr;
    logic          b_rd_i, b_rd_d, b_dv_i, b_dv_d, m_rd, m_ack, x_inv, inv;
    logic [LN-1:0] b_rdata_i, b_rdata_d, m_rdata;
    logic [1:0]    st;

    int n_vec = 0;
    int n_err = 0;
    int mrd_cnt;
    logic [LN-1:0] pat;

    bus_arb dut (
        .clk(clk), .rst_n(rst_n),
        .b_addr_i(b_addr_i), .b_rd_i(b_rd_i), .b_rdata_i(b_rdata_i), .b_dv_i(b_dv_i),
        .b_addr_d(b_addr_d), .b_rd_d(b_rd_d), .b_rdata_d(b_rdata_d), .b_dv_d(b_dv_d),
        .m_addr(m_addr), .m_rd(m_rd), .m_rdata(m_rdata), .m_ack(m_ack),
        .x_inv_addr(x_inv_addr), .x_inv(x_inv), .b_inv_addr(b_inv_addr), .inv(inv),
        .dbg_state(st)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LN-1:0] obs, input logic [LN-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; b_addr_i = '0; b_addr_d = '0; b_rd_i = 1'b0; b_rd_d = 1'b0;
        m_rdata = '0; m_ack = 1'b0; x_inv = 1'b0; x_inv_addr = '0;
        pat = {16{32'hA5C3_0F1E}};

        // Reset values
        tick(); tick(); #2;
        chk("rst_state", st, ST_IDLE);
        chk("rst_m_rd", m_rd, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_dv_i", b_dv_i, 0);
        chk("rst_dv_d", b_dv_d, 0);
        chk("rst_inv", inv, 0);
        chk("rst_inv_addr", b_inv_addr, 0);
        tick(); rst_n = 1'b1;

        // Single dmem fill of 0x100, ack on the third grant cycle
        tick(); b_rd_d = 1'b1; b_addr_d = 58'h100; #2;
        chk("t1_idle", st, ST_IDLE);
        mrd_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (c == 2) begin m_ack = 1'b1; m_rdata = pat; end
            #2;
            if (m_rd) mrd_cnt++;
            if (c == 0) begin
                chk("t1_m_addr", m_addr, 58'h100);
                chk("t1_gnt_d", st, ST_GNT_D);
                chk("t1_dv_d_early", b_dv_d, 0);
            end
        end
        chk("t1_dv_d", b_dv_d, 1);
        chk("t1_dv_i", b_dv_i, 0);
        chk("t1_rdata_d", b_rdata_d, pat);
        chk("t1_rdata_i", b_rdata_i, pat);
        tick(); m_ack = 1'b0; b_rd_d = 1'b0; #2;
        chk("t1_done", st, ST_DONE);
        chk("t1_done_m_rd", m_rd, 0);
        chk("t1_done_dv_d", b_dv_d, 0);
        chk("t1_done_m_addr", m_addr, 58'h100);
        tick(); #2;
        if (m_rd) mrd_cnt++;
        chk("t1_idle_after", st, ST_IDLE);
        chk("t1_mrd_cycles", mrd_cnt, 3);

        // Tie after reset: dmem first; dmem re-requests so the next tie goes to imem
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        b_rd_i = 1'b1; b_addr_i = 58'h0A0; b_rd_d = 1'b1; b_addr_d = 58'h0D0;
        tick(); #2;
        chk("t2_first_gnt", st, ST_GNT_D);
        chk("t2_first_addr", m_addr, 58'h0D0);
        tick(); m_ack = 1'b1; m_rdata = ~pat; #2;
        chk("t2_dv_d", b_dv_d, 1);
        chk("t2_dv_i", b_dv_i, 0);
        chk("t2_rdata_i", b_rdata_i, ~pat);
        tick(); m_ack = 1'b0; b_addr_d = 58'h0D4; #2;
        chk("t2_done", st, ST_DONE);
        tick(); #2;
        chk("t2_idle", st, ST_IDLE);
        tick(); #2;
        chk("t2_second_gnt", st, ST_GNT_I);
        chk("t2_second_addr", m_addr, 58'h0A0);
        tick(); m_ack = 1'b1; #2;
        chk("t2_dv_i2", b_dv_i, 1);
        chk("t2_dv_d2", b_dv_d, 0);
        tick(); m_ack = 1'b0; b_rd_i = 1'b0; #2;
        tick(); #2;
        tick(); #2;
        chk("t2_third_gnt", st, ST_GNT_D);
        chk("t2_third_addr", m_addr, 58'h0D4);
        tick(); m_ack = 1'b1; #2;
        tick(); m_ack = 1'b0; b_rd_d = 1'b0; #2;
        tick(); #2;

        // Requester keeps rd one cycle past dv: DONE exactly once, no re-grant
        tick(); b_rd_i = 1'b1; b_addr_i = 58'h055; #2;
        tick(); m_ack = 1'b1; #2;
        chk("t3_dv_i", b_dv_i, 1);
        tick(); m_ack = 1'b0; #2;
        chk("t3_done", st, ST_DONE);
        chk("t3_done_m_rd", m_rd, 0);
        tick(); b_rd_i = 1'b0; #2;
        chk("t3_idle", st, ST_IDLE);
        tick(); #2;
        chk("t3_no_regrant", st, ST_IDLE);
        chk("t3_no_m_rd", m_rd, 0);

        // Plain invalidate in IDLE goes out one cycle later
        x_inv = 1'b1; x_inv_addr = 58'h3AB; #1;
        chk("t4_inv_same", inv, 0);
        tick(); x_inv = 1'b0; #2;
        chk("t4_inv", inv, 1);
        chk("t4_inv_addr", b_inv_addr, 58'h3AB);
        tick(); #2;
        chk("t4_inv_once", inv, 0);

        // Invalidate hitting the dmem fill of 0x100 waits for DONE; 0x200 passes
        b_rd_d = 1'b1; b_addr_d = 58'h100;
        tick(); x_inv = 1'b1; x_inv_addr = 58'h100; #2;
        chk("t5_gnt", st, ST_GNT_D);
        tick(); x_inv_addr = 58'h200; #2;
        chk("t5_held", inv, 0);
        tick(); x_inv = 1'b0; m_ack = 1'b1; #2;
        chk("t5_fwd", inv, 1);
        chk("t5_fwd_addr", b_inv_addr, 58'h200);
        tick(); m_ack = 1'b0; b_rd_d = 1'b0; #2;
        chk("t5_done", st, ST_DONE);
        chk("t5_pend_inv", inv, 1);
        chk("t5_pend_addr", b_inv_addr, 58'h100);
        tick(); #2;
        chk("t5_after", inv, 0);

        // Two matching invalidates during a fill merge into one issue
        b_rd_d = 1'b1; b_addr_d = 58'h300;
        tick(); x_inv = 1'b1; x_inv_addr = 58'h300; #2;
        tick(); #2;
        chk("t6_held1", inv, 0);
        tick(); x_inv = 1'b0; m_ack = 1'b1; #2;
        chk("t6_held2", inv, 0);
        tick(); m_ack = 1'b0; b_rd_d = 1'b0; #2;
        chk("t6_issue", inv, 1);
        chk("t6_issue_addr", b_inv_addr, 58'h300);
        tick(); #2;
        chk("t6_single", inv, 0);
        tick(); #2;
        chk("t6_single2", inv, 0);

        // Reset mid GNT_I drops m_rd at once; a later ack produces no dv
        b_rd_i = 1'b1; b_addr_i = 58'h077;
        tick(); #2;
        chk("t7_gnt_i", st, ST_GNT_I);
        chk("t7_m_rd", m_rd, 1);
        rst_n = 1'b0; b_rd_i = 1'b0; #1;
        chk("t7_async_m_rd", m_rd, 0);
        chk("t7_async_state", st, ST_IDLE);
        chk("t7_async_m_addr", m_addr, 0);
        tick(); rst_n = 1'b1;
        tick(); m_ack = 1'b1; #2;
        chk("t7_no_dv_i", b_dv_i, 0);
        chk("t7_no_dv_d", b_dv_d, 0);
        tick(); m_ack = 1'b0; #2;
        chk("t7_idle", st, ST_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
